// File: rtl/spi_pkg.sv
// Shared constants for the SPI master/slave pair: host register map,
// status bit positions and slave FSM encoding.
package spi_pkg;

  // Host register addresses (shared with the master block)
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_CNT  = 2'b10;

  // Status register bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_FULL  = 2;
  localparam int STAT_OVERRUN  = 3;
  localparam int STAT_UNDERRUN = 4;

  // bit_cnt must reach 8, so it needs 4 bits
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchronizer; keep the previous
  // synced level for edge detection. RST_VAL lets SS_N reset deselected.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;

endmodule

// File: rtl/spi_slave_mode0.sv
// SPI mode-0 slave: oversampled SCLK/SS_N/MOSI, MSB-first 8-bit frames,
// one-byte RX/TX buffering with overrun/underrun flags, host register port.
module spi_slave_mode0
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [1:0] i_address,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       i_sclk,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic       o_irq
);

  logic sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
    .o_level(), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_ss_n),
    .o_level(ss_s), .o_rise(ss_rise), .o_fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
    .o_level(mosi_s), .o_rise(), .o_fall()
  );

  spi_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           tx_hold_q, tx_hold_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  // Only 7 bits are kept: the 8th received bit goes straight into rx_data.
  logic [6:0]           rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 tx_full_q, tx_full_d;
  logic                 rx_full_q, rx_full_d;
  logic                 overrun_q, overrun_d;
  logic                 underrun_q, underrun_d;
  logic                 busy;

  logic host_rd, wr_data, wr_stat, rd_data, reload;
  logic [7:0] status;

  assign host_rd = i_cs & i_rd;
  assign wr_data = i_cs & i_wr & (i_address == ADDR_DATA);
  assign wr_stat = i_cs & i_wr & (i_address == ADDR_STAT);
  assign rd_data = host_rd & (i_address == ADDR_DATA);

  // A deselect takes priority over any in-flight shift or reload.
  assign reload = !ss_rise &&
                  ((state_q == S_LOAD) ||
                   (state_q == S_SHIFT && sclk_fall && bit_cnt_q == 4'd8));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: select starts a frame, deselect aborts from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_fall) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_SHIFT;
      default: state_d = S_IDLE;
    endcase
    if (ss_rise) state_d = S_IDLE;
  end

  // FSM outputs: MISO is driven from the shifter only inside a frame
  always_comb begin
    busy   = (state_q != S_IDLE);
    o_miso = busy ? tx_shift_q[7] : 1'b0;
  end

  // Datapath next state. Host clears are applied first so that a
  // coincident set event from the shifter wins.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    tx_hold_d  = tx_hold_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    tx_full_d  = tx_full_q;
    rx_full_d  = rx_full_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (wr_data) begin
      tx_hold_d = i_data;
      tx_full_d = 1'b1;
    end
    if (wr_stat) begin
      if (i_data[STAT_OVERRUN])  overrun_d  = 1'b0;
      if (i_data[STAT_UNDERRUN]) underrun_d = 1'b0;
    end
    if (rd_data) rx_full_d = 1'b0;

    if (reload) begin
      // Shifter takes the old tx_hold; a same-cycle host write keeps tx_full.
      tx_shift_d = tx_full_q ? tx_hold_q : UNDERRUN_BYTE;
      if (!tx_full_q)    underrun_d = 1'b1;
      else if (!wr_data) tx_full_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (state_q == S_SHIFT && sclk_rise && !ss_rise) begin
      rx_shift_d = {rx_shift_q[5:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd7) begin
        rx_data_d = {rx_shift_q, mosi_s};
        rx_full_d = 1'b1;
        if (rx_full_q && !rd_data) overrun_d = 1'b1;
      end
    end else if (state_q == S_SHIFT && sclk_fall && !ss_rise &&
                 bit_cnt_q != 4'd0 && bit_cnt_q < 4'd8) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    // Partial byte is dropped; rx_full/rx_data are left alone.
    if (ss_rise) bit_cnt_d = '0;
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_cnt_q  <= '0;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_full_q  <= 1'b0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      tx_hold_q  <= tx_hold_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      tx_full_q  <= tx_full_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Status word and host read mux; o_data idles at zero
  always_comb begin
    status                = '0;
    status[STAT_BUSY]     = busy;
    status[STAT_RX_FULL]  = rx_full_q;
    status[STAT_TX_FULL]  = tx_full_q;
    status[STAT_OVERRUN]  = overrun_q;
    status[STAT_UNDERRUN] = underrun_q;
    o_data = 8'h00;
    if (host_rd) begin
      case (i_address)
        ADDR_DATA: o_data = rx_data_q;
        ADDR_STAT: o_data = status;
        ADDR_CNT:  o_data = {4'b0, bit_cnt_q};
        default:   o_data = 8'h00;
      endcase
    end
  end

  assign o_miso_oe = ~ss_s;
  assign o_irq     = rx_full_q | overrun_q;

endmodule

// File: tb/tb_spi_slave_mode0.sv
// Directed bench for spi_slave_mode0 with a queue-based scoreboard:
// stimulus pushes expected host-read and MISO bytes, a monitor pops them.
module tb_spi_slave_mode0;
  localparam int H     = 4;  // SCLK half period in i_clk cycles
  localparam int SETUP = 6;  // SS_N fall to first SCLK rise

  logic       clk = 1'b0;
  logic       rst_n, cs, wr, rd, sclk, ss_n, mosi;
  logic [1:0] addr;
  logic [7:0] wdata, rdata;
  logic       miso, miso_oe, irq;

  always #5 clk = ~clk;

  spi_slave_mode0 #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'hFF)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_wr(wr), .i_rd(rd),
    .i_address(addr), .i_data(wdata), .o_data(rdata),
    .i_sclk(sclk), .i_ss_n(ss_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_irq(irq)
  );

  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t       rd_q[$];
  exp_t       miso_q[$];
  logic [7:0] miso_obs[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: compare every host read and every captured MISO byte
  always @(negedge clk) begin
    exp_t e;
    if (cs && rd) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL stray_read: got %02h expected no read", rdata);
      end else begin
        e = rd_q.pop_front();
        check(e.name, rdata, e.val);
      end
    end
    while (miso_obs.size() > 0) begin
      if (miso_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL stray_miso: got %02h expected none", miso_obs.pop_front());
      end else begin
        e = miso_q.pop_front();
        check(e.name, miso_obs.pop_front(), e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1; wr = 1; addr = a; wdata = d;
    tick();
    cs = 0; wr = 0;
  endtask

  task automatic host_read(input string name, input logic [1:0] a, input logic [7:0] exp);
    exp_t e;
    e.name = name; e.val = exp;
    rd_q.push_back(e);
    cs = 1; rd = 1; addr = a;
    tick();
    cs = 0; rd = 0;
  endtask

  // Clock out nbits MSB-first; master samples MISO at each SCLK rise
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (H) tick();
      sclk = 1;
      cap = {cap[6:0], miso};
      repeat (H) tick();
      sclk = 0;
    end
  endtask

  task automatic spi_frame(input string name, input int nb,
                           input logic [7:0] b0, input logic [7:0] e0,
                           input logic [7:0] b1, input logic [7:0] e1);
    exp_t e;
    logic [7:0] cap;
    e.name = {name, "_miso0"}; e.val = e0; miso_q.push_back(e);
    if (nb == 2) begin
      e.name = {name, "_miso1"}; e.val = e1; miso_q.push_back(e);
    end
    ss_n = 0;
    repeat (SETUP) tick();
    spi_bits(b0, 8, cap);
    miso_obs.push_back(cap);
    if (nb == 2) begin
      spi_bits(b1, 8, cap);
      miso_obs.push_back(cap);
    end
    repeat (H) tick();
    ss_n = 1; mosi = 0;
    repeat (SETUP) tick();
  endtask

  initial begin
    logic [7:0] cap;
    rst_n = 0; cs = 0; wr = 0; rd = 0; addr = 2'b00; wdata = 8'h00;
    sclk = 0; ss_n = 1; mosi = 0;
    repeat (3) tick();
    check("rst_miso", {7'b0, miso}, 8'h00);
    check("rst_oe",   {7'b0, miso_oe}, 8'h00);
    check("rst_irq",  {7'b0, irq}, 8'h00);
    check("rst_data", rdata, 8'h00);
    rst_n = 1;
    tick();
    host_read("rst_stat", 2'b01, 8'h00);
    host_read("rst_cnt",  2'b10, 8'h00);
    host_read("rst_rx",   2'b00, 8'h00);
    host_read("rst_r3",   2'b11, 8'h00);

    // Single byte; final SCLK fall reloads with tx empty -> underrun
    host_write(2'b00, 8'hA5);
    host_read("t1_stat_pre", 2'b01, 8'h04);
    spi_frame("t1", 1, 8'h3C, 8'hA5, 8'h00, 8'h00);
    check("t1_irq", {7'b0, irq}, 8'h01);
    host_read("t1_stat", 2'b01, 8'h12);
    host_read("t1_rx",   2'b00, 8'h3C);
    host_read("t1_stat2", 2'b01, 8'h10);
    check("t1_irq_clr", {7'b0, irq}, 8'h00);
    host_write(2'b01, 8'h10);
    host_read("t1_stat3", 2'b01, 8'h00);

    // Back-to-back, first byte not read -> overrun
    host_write(2'b00, 8'hC3);
    fork
      spi_frame("t2", 2, 8'h11, 8'hC3, 8'h22, 8'h5A);
      begin repeat (20) tick(); host_write(2'b00, 8'h5A); end
    join
    host_read("t2_stat", 2'b01, 8'h1A);
    host_read("t2_rx",   2'b00, 8'h22);
    host_read("t2_stat2", 2'b01, 8'h18);
    check("t2_irq_ovr", {7'b0, irq}, 8'h01);
    host_write(2'b01, 8'h18);
    host_read("t2_stat3", 2'b01, 8'h00);

    // Underrun
    spi_frame("t3", 1, 8'h00, 8'hFF, 8'h00, 8'h00);
    host_read("t3_stat", 2'b01, 8'h12);
    host_read("t3_rx",   2'b00, 8'h00);
    host_write(2'b01, 8'h10);
    host_read("t3_stat2", 2'b01, 8'h00);

    // Abort after 5 rises, then a clean frame
    host_write(2'b00, 8'hE7);
    ss_n = 0;
    repeat (SETUP) tick();
    spi_bits(8'h5A, 5, cap);
    repeat (H) tick();
    host_read("t4_cnt_mid", 2'b10, 8'h05);
    ss_n = 1;
    repeat (SETUP) tick();
    host_read("t4_cnt",  2'b10, 8'h00);
    host_read("t4_stat", 2'b01, 8'h00);
    host_write(2'b00, 8'h3D);
    spi_frame("t4", 1, 8'hC5, 8'h3D, 8'h00, 8'h00);
    host_read("t4_stat2", 2'b01, 8'h12);
    host_read("t4_rx",    2'b00, 8'hC5);
    host_write(2'b01, 8'h10);
    host_read("t4_stat3", 2'b01, 8'h00);

    // Coincident events. Offsets count ticks from the SS_N fall:
    // reload after byte 1 lands at tick 73, byte 2 completes at tick 133.
    host_write(2'b00, 8'h81);
    fork
      spi_frame("t5", 2, 8'h96, 8'h81, 8'h69, 8'h42);
      begin
        repeat (20) tick();
        host_write(2'b00, 8'h42);
        repeat (51) tick();
        host_write(2'b00, 8'h24);          // same edge as reload
        tick();
        host_read("t5_stat_mid", 2'b01, 8'h07);
        repeat (57) tick();
        host_read("t5_rx_coinc", 2'b00, 8'h96); // same edge as byte 2 done
      end
    join
    host_read("t5_stat", 2'b01, 8'h02);
    host_read("t5_rx",   2'b00, 8'h69);
    host_read("t5_stat2", 2'b01, 8'h00);

    // Reset mid-frame at bit 4
    host_write(2'b00, 8'hFF);
    ss_n = 0;
    repeat (SETUP) tick();
    spi_bits(8'hAA, 4, cap);
    check("t6_oe_pre", {7'b0, miso_oe}, 8'h01);
    rst_n = 0; ss_n = 1;
    tick();
    check("t6_miso", {7'b0, miso}, 8'h00);
    check("t6_oe",   {7'b0, miso_oe}, 8'h00);
    check("t6_irq",  {7'b0, irq}, 8'h00);
    check("t6_data", rdata, 8'h00);
    rst_n = 1;
    tick();
    host_read("t6_stat", 2'b01, 8'h00);
    host_read("t6_cnt",  2'b10, 8'h00);
    host_write(2'b00, 8'h96);
    spi_frame("t6", 1, 8'h5B, 8'h96, 8'h00, 8'h00);
    host_read("t6_stat2", 2'b01, 8'h12);
    host_read("t6_rx",    2'b00, 8'h5B);

    repeat (4) tick();
    check("pending_exp", 8'(rd_q.size() + miso_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case anything stalls
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
